potential_adder_array: RTL and testbench

Time-multiplexed LIF potential update engine for N neurons. It replaces the per-neuron potential_adderNN instances. During a timestep it accumulates incoming synaptic weights per neuron. At timestep end it serially applies leak, integration, threshold compare, reset and refractory handling for each neuron, one neuron per cycle, streaming spikes to the downstream spike encoder. Arithmetic is signed fixed point; the threshold and the reset mode are runtime-selectable.

---
 rtl/potential_adder_array_if.sv | 32 +++
 rtl/potential_adder_array.sv | 133 +++++++++++++
 tb/tb_potential_adder_array.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/potential_adder_array_if.sv
// Handshake and data bundle for the time-multiplexed LIF potential update engine.
// The master side drives the timestep control and the weight stream; the slave side is the engine.
interface potential_adder_array_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic [1:0]               mode;
    logic signed [DATA_W-1:0] v_threshold;
    logic                     ts_start;
    logic                     ts_end;
    logic                     w_valid;
    logic                     w_ready;
    logic [IDX_W-1:0]         w_idx;
    logic signed [DATA_W-1:0] w_data;
    logic                     spike_valid;
    logic [IDX_W-1:0]         spike_idx;
    logic                     spike;
    logic signed [DATA_W-1:0] potential_out;
    logic                     busy;
    logic                     done;
    logic                     idx_err;

    modport master (
        output mode, v_threshold, ts_start, ts_end, w_valid, w_idx, w_data,
        input  w_ready, spike_valid, spike_idx, spike, potential_out, busy, done, idx_err
    );

    modport slave (
        input  mode, v_threshold, ts_start, ts_end, w_valid, w_idx, w_data,
        output w_ready, spike_valid, spike_idx, spike, potential_out, busy, done, idx_err
    );
endinterface

// File: rtl/potential_adder_array.sv
// Time-multiplexed leaky integrate-and-fire engine: accumulates weights per neuron during a
// timestep, then sweeps all neurons one per cycle applying leak, integration, threshold and reset.
module potential_adder_array #(
    parameter int N_NEURONS    = 30,
    parameter int DATA_W       = 32,
    parameter int IDX_W        = $clog2(N_NEURONS),
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRAC_STEPS = 0
) (
    input logic                    CLK,
    input logic                    RESET,
    potential_adder_array_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] clamp(input logic signed [DATA_W:0] x);
        if (x[DATA_W] != x[DATA_W-1]) return x[DATA_W] ? MINV : MAXV;
        return x[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return clamp(s);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return clamp(s);
    endfunction

    state_t                   state;
    logic [IDX_W-1:0]         ptr;
    logic [1:0]               mode_q;
    logic signed [DATA_W-1:0] vth_q;
    logic signed [DATA_W-1:0] pot    [N_NEURONS];
    logic signed [DATA_W-1:0] acc    [N_NEURONS];
    logic [RW-1:0]            refrac [N_NEURONS];

    logic signed [DATA_W-1:0] v_cur, v_leak, sum, v_new;
    logic                     in_refrac, fire, w_in_range;

    always_comb begin
        v_cur      = pot[ptr];
        v_leak     = (mode_q == 2'b10) ? v_cur : sat_sub(v_cur, v_cur >>> LEAK_SHIFT);
        in_refrac  = (refrac[ptr] != '0);
        sum        = sat_add(v_leak, acc[ptr]);
        fire       = !in_refrac && (sum >= vth_q);
        v_new      = sum;
        if (in_refrac)
            v_new = v_leak;
        else if (fire)
            v_new = (mode_q == 2'b01) ? '0 : sat_sub(sum, vth_q);
        w_in_range = ({1'b0, bus.w_idx} < (IDX_W+1)'(N_NEURONS));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state             <= IDLE;
            ptr               <= '0;
            mode_q            <= '0;
            vth_q             <= '0;
            bus.spike_valid   <= 1'b0;
            bus.spike_idx     <= '0;
            bus.spike         <= 1'b0;
            bus.potential_out <= '0;
            bus.done          <= 1'b0;
            bus.idx_err       <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                pot[i]    <= '0;
                acc[i]    <= '0;
                refrac[i] <= '0;
            end
        end else begin
            bus.spike_valid <= 1'b0;
            bus.spike       <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ts_start) begin
                        mode_q <= bus.mode;
                        vth_q  <= bus.v_threshold;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.w_valid) begin
                        if (w_in_range)
                            acc[bus.w_idx] <= sat_add(acc[bus.w_idx], bus.w_data);
                        else
                            bus.idx_err <= 1'b1;
                    end
                    if (bus.ts_end) begin
                        state <= UPDATE;
                        ptr   <= '0;
                    end
                end
                UPDATE: begin
                    pot[ptr] <= v_new;
                    acc[ptr] <= '0;
                    if (in_refrac)
                        refrac[ptr] <= refrac[ptr] - RW'(1);
                    else if (fire)
                        refrac[ptr] <= RW'(REFRAC_STEPS);
                    bus.spike_valid   <= 1'b1;
                    bus.spike_idx     <= ptr;
                    bus.spike         <= fire;
                    bus.potential_out <= v_new;
                    if (ptr == IDX_W'(N_NEURONS - 1))
                        state <= DONE;
                    else
                        ptr <= ptr + 1'b1;
                end
                DONE: begin
                    // The last neuron's result is visible during this state, so done lands one cycle later.
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.w_ready = (state == ACCUM);
endmodule

// File: tb/tb_potential_adder_array.sv
// Randomized and directed bench for potential_adder_array, checked against a per-timestep
// arithmetic model of the neuron rules.
module tb_potential_adder_array;
    localparam int N      = 30;
    localparam int DW     = 32;
    localparam int IW     = 5;
    localparam int REFRAC = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        int     idx;
        longint data;
    } wt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    potential_adder_array_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    potential_adder_array #(
        .N_NEURONS(N), .DATA_W(DW), .IDX_W(IW), .LEAK_SHIFT(3), .REFRAC_STEPS(REFRAC)
    ) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    longint    m_pot [N];
    longint    m_acc [N];
    int        m_ref [N];
    bit        m_err;
    logic      exp_spike [N];
    logic [31:0] exp_pot [N];
    wt_t       wq[$];

    // observations from the last sweep
    logic      obs_spike [N];
    logic [31:0] obs_pot [N];
    int        obs_nvalid, obs_ndone;
    bit        obs_order_bad, obs_done_ok, obs_timeout, obs_ready_bad;

    function automatic longint clamp(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint floor_div8(input longint v);
        if (v >= 0) return v / 8;
        return -((-v + 7) / 8);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_pot[i] = 0;
            m_acc[i] = 0;
            m_ref[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_ts(input int md, input longint vth);
        longint vl, s, nv;
        bit sp;
        foreach (wq[k]) begin
            if (wq[k].idx < N) m_acc[wq[k].idx] = clamp(m_acc[wq[k].idx] + wq[k].data);
            else m_err = 1;
        end
        for (int i = 0; i < N; i++) begin
            vl = (md == 2) ? m_pot[i] : clamp(m_pot[i] - floor_div8(m_pot[i]));
            if (m_ref[i] > 0) begin
                nv = vl;
                sp = 0;
                m_ref[i]--;
            end else begin
                s  = clamp(vl + m_acc[i]);
                sp = (s >= vth);
                nv = s;
                if (sp) begin
                    nv = (md == 1) ? 0 : clamp(s - vth);
                    m_ref[i] = REFRAC;
                end
            end
            m_pot[i] = nv;
            m_acc[i] = 0;
            exp_spike[i] = sp;
            exp_pot[i] = nv[31:0];
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // Drives one full timestep from wq and records the sweep; the model is advanced alongside.
    task automatic run_ts(input int md, input longint vth, input bit end_with_weight);
        int cyc, last_v, done_c;
        logic [1:0] md2;
        md2 = 2'(md);
        model_ts(md, vth);
        for (int i = 0; i < N; i++) begin
            obs_spike[i] = 1'bx;
            obs_pot[i]   = 'x;
        end
        @(posedge clk); #1;
        bus.mode        = md2;
        bus.v_threshold = vth[31:0];
        bus.ts_start    = 1'b1;
        @(posedge clk); #1;
        bus.ts_start    = 1'b0;
        bus.mode        = ~md2;
        bus.v_threshold = $urandom;
        obs_ready_bad   = 0;
        foreach (wq[k]) begin
            bus.w_valid = 1'b1;
            bus.w_idx   = 5'(wq[k].idx);
            bus.w_data  = 32'(wq[k].data);
            if (end_with_weight && k == wq.size() - 1) bus.ts_end = 1'b1;
            if (bus.w_ready !== 1'b1) obs_ready_bad = 1;
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        if (!(end_with_weight && wq.size() > 0)) begin
            bus.ts_end = 1'b1;
            @(posedge clk); #1;
        end
        bus.ts_end = 1'b0;
        cyc = 0; last_v = -10; done_c = -1;
        obs_nvalid = 0; obs_ndone = 0; obs_order_bad = 0;
        while (cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.spike_valid === 1'b1) begin
                if (bus.spike_idx !== 5'(obs_nvalid)) obs_order_bad = 1;
                if (bus.spike_idx < N) begin
                    obs_spike[bus.spike_idx] = bus.spike;
                    obs_pot[bus.spike_idx]   = bus.potential_out;
                end
                obs_nvalid++;
                last_v = cyc;
            end
            if (bus.done === 1'b1) begin
                obs_ndone++;
                if (done_c < 0) done_c = cyc;
            end
            if (done_c > 0 && cyc >= done_c + 2) break;
        end
        obs_timeout = (done_c < 0);
        obs_done_ok = (obs_ndone == 1) && (done_c == last_v + 1);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.w_ready, bus.spike_valid, bus.spike, bus.done, bus.idx_err} !== 6'b0 ||
            bus.spike_idx !== 5'd0 || bus.potential_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b rdy=%b sv=%b sp=%b done=%b err=%b idx=%0d pot=%h required all zero",
                     bus.busy, bus.w_ready, bus.spike_valid, bus.spike, bus.done, bus.idx_err,
                     bus.spike_idx, bus.potential_out);
        end
        bus.ts_end = 1'b1;
        @(posedge clk); #1;
        bus.ts_end = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.spike_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ts_end_in_idle busy=%b sv=%b required 0 0", bus.busy, bus.spike_valid);
        end
    endtask

    task automatic test_single_spike();
        wq.delete();
        wq.push_back('{3, 64'sh00300000});
        run_ts(0, 64'sh00280000, 0);
        n_tests++;
        if (obs_timeout || obs_nvalid !== N || obs_order_bad || !obs_done_ok || obs_ready_bad) begin
            n_fail++;
            $display("FAIL single_sweep valid=%0d order_bad=%0b done_ok=%0b timeout=%0b rdy_bad=%0b required %0d 0 1 0 0",
                     obs_nvalid, obs_order_bad, obs_done_ok, obs_timeout, obs_ready_bad, N);
        end
        n_tests++;
        if (obs_spike[3] !== 1'b1 || obs_pot[3] !== 32'h00080000) begin
            n_fail++;
            $display("FAIL single_n3 spike=%b pot=%h required 1 00080000", obs_spike[3], obs_pot[3]);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                n_fail++;
                $display("FAIL single_n%0d spike=%b pot=%h required %b %h", i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
            end
        end
    endtask

    task automatic test_leak();
        wq.delete();
        run_ts(0, 64'sh00280000, 0);
        n_tests++;
        if (obs_spike[3] !== 1'b0 || obs_pot[3] !== 32'h00070000) begin
            n_fail++;
            $display("FAIL leak_n3 spike=%b pot=%h required 0 00070000", obs_spike[3], obs_pot[3]);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                n_fail++;
                $display("FAIL leak_n%0d spike=%b pot=%h required %b %h", i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
            end
        end
    endtask

    task automatic test_reset_to_zero();
        wq.delete();
        wq.push_back('{0, 64'sh00200000});
        wq.push_back('{0, 64'sh00200000});
        run_ts(1, 64'sh00280000, 1);
        n_tests++;
        if (obs_spike[0] !== 1'b1 || obs_pot[0] !== 32'h00000000 || !obs_done_ok || obs_timeout) begin
            n_fail++;
            $display("FAIL zero_mode_n0 spike=%b pot=%h done_ok=%0b required 1 00000000 1", obs_spike[0], obs_pot[0], obs_done_ok);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                n_fail++;
                $display("FAIL zero_mode_n%0d spike=%b pot=%h required %b %h", i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
            end
        end
    endtask

    task automatic test_refractory();
        logic want [4];
        want[0] = 1'b1; want[1] = 1'b0; want[2] = 1'b0; want[3] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wq.delete();
            wq.push_back('{5, 64'sh00300000});
            run_ts(0, 64'sh00280000, 0);
            n_tests++;
            if (obs_spike[5] !== want[t]) begin
                n_fail++;
                $display("FAIL refrac_ts%0d_n5 spike=%b required %b", t + 1, obs_spike[5], want[t]);
            end
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                    n_fail++;
                    $display("FAIL refrac_ts%0d_n%0d spike=%b pot=%h required %b %h", t + 1, i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
                end
            end
        end
    endtask

    task automatic test_saturation_idx_err();
        wq.delete();
        wq.push_back('{1, 64'sh7FFF0000});
        wq.push_back('{1, 64'sh7FFF0000});
        run_ts(0, 64'sh7FFFFFFF, 0);
        n_tests++;
        if (obs_spike[1] !== 1'b1 || obs_pot[1] !== 32'h00000000 || bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_n1 spike=%b pot=%h err=%b required 1 00000000 0", obs_spike[1], obs_pot[1], bus.idx_err);
        end
        wq.delete();
        wq.push_back('{31, 64'sh00500000});
        run_ts(0, 64'sh00280000, 0);
        n_tests++;
        if (bus.idx_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_err_set err=%b required 1", bus.idx_err);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                n_fail++;
                $display("FAIL idx_err_n%0d spike=%b pot=%h required %b %h", i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
            end
        end
    endtask

    task automatic test_random();
        longint vth, d;
        int nw, md;
        for (int t = 0; t < 8; t++) begin
            wq.delete();
            nw = $urandom_range(0, 14);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 7) == 0) d = longint'($urandom_range(0, 32'h00FFFFFF)) + 64'sh7F000000;
                else d = longint'($urandom_range(0, 32'h00A00000)) - 64'sh00500000;
                if ($urandom_range(0, 1) == 0) d = -d;
                wq.push_back('{int'($urandom_range(0, 31)), clamp(d)});
            end
            md  = int'($urandom_range(0, 3));
            vth = longint'($urandom_range(32'h00100000, 32'h00600000));
            if ($urandom_range(0, 5) == 0) vth = -vth;
            run_ts(md, vth, 1'($urandom_range(0, 1)));
            n_tests++;
            if (obs_timeout || obs_nvalid !== N || obs_order_bad || !obs_done_ok || obs_ready_bad || bus.idx_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_ts%0d_sweep valid=%0d order_bad=%0b done_ok=%0b timeout=%0b rdy_bad=%0b err=%b required %0d 0 1 0 0 %b",
                         t, obs_nvalid, obs_order_bad, obs_done_ok, obs_timeout, obs_ready_bad, bus.idx_err, N, m_err);
            end
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (obs_spike[i] !== exp_spike[i] || obs_pot[i] !== exp_pot[i]) begin
                    n_fail++;
                    $display("FAIL rand_ts%0d_n%0d spike=%b pot=%h required %b %h", t, i, obs_spike[i], obs_pot[i], exp_spike[i], exp_pot[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit seen, bad_done;
        @(posedge clk); #1;
        bus.mode = 2'b00; bus.v_threshold = 32'h00100000; bus.ts_start = 1'b1;
        @(posedge clk); #1;
        bus.ts_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.w_valid = 1'b1;
            bus.w_idx   = (k == 5) ? 5'd30 : 5'(k * 4);
            bus.w_data  = 32'h00400000;
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        bus.ts_end = 1'b1;
        @(posedge clk); #1;
        bus.ts_end = 1'b0;
        cyc = 0; seen = 0;
        while (cyc < 60 && !seen) begin
            @(negedge clk);
            cyc++;
            if (bus.spike_valid === 1'b1 && bus.spike_idx === 5'd9) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_reach_ptr10 seen=0 required 1");
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.spike_valid !== 1'b0 || bus.done !== 1'b0 || bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state busy=%b sv=%b done=%b err=%b required 0 0 0 0", bus.busy, bus.spike_valid, bus.done, bus.idx_err);
        end
        rst = 1'b0;
        model_clear();
        bad_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.spike_valid !== 1'b0) bad_done = 1;
        end
        n_tests++;
        if (bad_done) begin
            n_fail++;
            $display("FAIL abort_no_done stray done/spike_valid=1 required 0");
        end
        wq.delete();
        run_ts(0, 64'sh00010000, 0);
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (obs_spike[i] !== 1'b0 || obs_pot[i] !== 32'h0 || obs_pot[i] !== exp_pot[i]) begin
                n_fail++;
                $display("FAIL abort_after_n%0d spike=%b pot=%h required 0 00000000", i, obs_spike[i], obs_pot[i]);
            end
        end
    endtask

    initial begin
        bus.mode = '0; bus.v_threshold = '0; bus.ts_start = 1'b0; bus.ts_end = 1'b0;
        bus.w_valid = 1'b0; bus.w_idx = '0; bus.w_data = '0;
        model_clear();
        test_reset();
        test_single_spike();
        test_leak();
        test_reset_to_zero();
        test_refractory();
        test_saturation_idx_err();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
